ibex_register_file_mp: RTL and testbench
========================================

Name: ibex_register_file_mp

Overview:
Parametrised multi-port flip-flop register file for the Ibex core, succeeding the single-write-port latch register file. It supports N read ports and M write ports, optional write-through forwarding, a per-register busy scoreboard for outstanding producers, and write-collision detection. It sits in the ID stage and is written from WB and LSU-response paths. It runs on the gated core clock clk_int.

Parameters:
RV32E, 0, 1 selects 16 registers (ADDR_WIDTH=4); 0 selects 32 registers (ADDR_WIDTH=5).
DataWidth, 32, register width in bits.
NumReadPorts, 2, number of read ports (1..4).
NumWritePorts, 2, number of write ports (1..3).
WriteThrough, 1, 1 forwards same-cycle write data to the read ports.
DummyInstructions, 0, 1 adds a shadow x0 register for dummy-instruction writes.

Ports:
clk_int  in  1  core clock (gated upstream).
rst_ni  in  1  reset, asynchronous, active-low.
dummy_instr_id_i  in  1  the instruction in ID is a dummy instruction.
raddr_i  in  NumReadPorts*5  read addresses; port r occupies bits [5r+4:5r].
rdata_o  out  NumReadPorts*DataWidth  read data, per port.
busy_o  out  NumReadPorts  the register addressed by each read port has a pending producer.
waddr_i  in  NumWritePorts*5  write addresses.
wdata_i  in  NumWritePorts*DataWidth  write data.
we_i  in  NumWritePorts  write enables.
lock_i  in  1  marks a register as busy (an instruction that writes it was issued).
lock_addr_i  in  5  address to mark busy.
wr_conflict_o  out  1  registered pulse: two or more enabled write ports targeted the same non-zero register in the previous cycle.

Behaviour:
- Address handling: only the low ADDR_WIDTH bits of every address are used; upper bits are ignored.
- Storage: registers 1..NUM_WORDS-1 are flops. All reset to 0 asynchronously.
- Reset values:
  - rdata_o is 0 for every port while in reset.
  - busy_o is 0.
  - wr_conflict_o is 0.
  - The busy vector and the shadow x0 register are cleared.
- Write timing: at the posedge of clk_int, each port p with we_i[p]=1 and a non-zero address updates that register with its wdata.
- Write collision:
  - If several enabled ports target the same non-zero register, the highest port index wins.
  - wr_conflict_o is asserted for exactly one cycle after that edge.
  - Writes to address 0 never count toward a collision.
- Reads are combinational: rdata_o[r] = mem[raddr_r].
- Write-through:
  - WriteThrough=1: if a write to the same non-zero address is enabled in the same cycle, the read returns the winning write data (0-cycle forwarding).
  - WriteThrough=0: the read returns the old value; the new value is visible from the next cycle.
- x0 reads:
  - DummyInstructions=0: x0 always reads 0. Writes to x0 are discarded.
  - DummyInstructions=1: a write to x0 on port 0 while dummy_instr_id_i=1 updates the shadow register r0_shadow; writes to x0 on other ports are discarded.
  - DummyInstructions=1: reading x0 returns r0_shadow when dummy_instr_id_i=1, otherwise 0.
  - Forwarding applies to x0 only in the dummy case.
- Scoreboard:
  - There is a busy bit per register 1..NUM_WORDS-1.
  - At each edge, lock_i with a non-zero lock_addr_i sets that bit.
  - Any enabled write (from any port) to a register clears its bit.
  - Simultaneous lock and write to the same register: set wins, because a new producer supersedes the retiring one.
  - lock_i to x0 is ignored.
- busy_o[r] is the combinational busy bit of raddr_r's register; x0 always reads as not busy. busy_o is not forwarded, so a write clearing the bit shows effect from the next cycle.
- Reset mid-operation clears storage, busy bits and the conflict pulse immediately. No pending write from before reset takes effect after it.
- Integer widths: no arithmetic. All port slicing is fixed-offset from the parameters.

Test Plan:
- Reset, then read all 32 addresses on both ports -> every rdata_o is 0 and busy_o=00; wr_conflict_o=0.
- Write x5=0xDEADBEEF via port 0, then read x5 next cycle on port 1 -> 0xDEADBEEF. Same-cycle read of x5 -> 0xDEADBEEF with WriteThrough=1, and the old value (0) with WriteThrough=0.
- Same cycle: port0 writes x7=0x11 and port1 writes x7=0x22 -> x7=0x22, and wr_conflict_o=1 for exactly one cycle. Both ports writing x0 -> no conflict, and x0 reads 0.
- lock x9, then read x9 -> busy_o=1. A write to x9 clears it the cycle after; lock and write to x9 in the same cycle -> busy stays 1.
- DummyInstructions=1: port0 writes x0=0xA5A5 with dummy_instr_id_i=1 -> x0 reads 0xA5A5 while dummy_instr_id_i=1 and 0 when it is 0.
- RV32E=1: write address 5'b10011 updates x3. Assert rst_ni low mid-burst with writes pending -> all registers and busy bits read 0 after release.

Source files
------------

// File: rtl/ibex_register_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : ibex_register_file_mp
// Description : Multi-port flip-flop register file for the ID stage. N read
//               ports, M write ports with highest-port-wins priority, optional
//               same-cycle write-through, per-register busy scoreboard,
//               registered write-collision pulse and optional shadow x0 for
//               dummy instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_register_file_mp #(
  parameter bit          RV32E             = 1'b0,
  parameter int unsigned DataWidth         = 32,
  parameter int unsigned NumReadPorts      = 2,
  parameter int unsigned NumWritePorts     = 2,
  parameter bit          WriteThrough      = 1'b1,
  parameter bit          DummyInstructions = 1'b0
) (
  input  logic                              clk_int,
  input  logic                              rst_ni,
  input  logic                              dummy_instr_id_i,
  input  logic [NumReadPorts*5-1:0]         raddr_i,
  output logic [NumReadPorts*DataWidth-1:0] rdata_o,
  output logic [NumReadPorts-1:0]           busy_o,
  input  logic [NumWritePorts*5-1:0]        waddr_i,
  input  logic [NumWritePorts*DataWidth-1:0] wdata_i,
  input  logic [NumWritePorts-1:0]          we_i,
  input  logic                              lock_i,
  input  logic [4:0]                        lock_addr_i,
  output logic                              wr_conflict_o
);

  localparam int unsigned ADDR_WIDTH = RV32E ? 4 : 5;
  localparam int unsigned NUM_WORDS  = 2 ** ADDR_WIDTH;

  // Write enables are masked by reset so nothing is forwarded while in reset.
  logic [NumWritePorts-1:0] w_we;
  logic [ADDR_WIDTH-1:0]    w_waddr [NumWritePorts];
  logic [DataWidth-1:0]     w_wdata [NumWritePorts];
  logic [ADDR_WIDTH-1:0]    w_lock_addr;
  // Per-word read view (storage, or forwarded write data) and busy view.
  logic [DataWidth-1:0]     w_rd_view [NUM_WORDS];
  logic [NUM_WORDS-1:0]     w_busy_view;
  logic [NUM_WORDS-1:0]     w_conflict_word;
  logic                     r_wr_conflict;
  // Upper address bits are ignored when ADDR_WIDTH < 5.
  logic                     w_unused_inputs;

  assign w_we            = we_i & {NumWritePorts{rst_ni}};
  assign w_lock_addr     = lock_addr_i[ADDR_WIDTH-1:0];
  assign w_unused_inputs = ^{raddr_i, waddr_i, lock_addr_i, dummy_instr_id_i};

  for (genvar p = 0; p < NumWritePorts; p++) begin : g_wport
    assign w_waddr[p] = waddr_i[5*p +: ADDR_WIDTH];
    assign w_wdata[p] = wdata_i[DataWidth*p +: DataWidth];
  end

  // x0 is never a real register and never busy or in conflict.
  assign w_conflict_word[0] = 1'b0;
  assign w_busy_view[0]     = 1'b0;

  for (genvar w = 1; w < NUM_WORDS; w++) begin : g_word
    logic                 w_we_word;
    logic [DataWidth-1:0] w_wdata_word;
    logic                 w_lock_hit;
    logic [DataWidth-1:0] r_q;
    logic                 r_busy;

    // Priority chain over write ports: later (higher) ports override earlier
    // ones, and a hit on top of an earlier hit flags a collision.
    for (genvar p = 0; p < NumWritePorts; p++) begin : g_prio
      logic                 w_hit;
      logic                 w_any;
      logic                 w_dup;
      logic [DataWidth-1:0] w_sel;

      assign w_hit = w_we[p] & (w_waddr[p] == ADDR_WIDTH'(w));
      if (p == 0) begin : g_first
        assign w_any = w_hit;
        assign w_dup = 1'b0;
        assign w_sel = w_wdata[p];
      end else begin : g_next
        assign w_any = g_prio[p-1].w_any | w_hit;
        assign w_dup = g_prio[p-1].w_dup | (g_prio[p-1].w_any & w_hit);
        assign w_sel = w_hit ? w_wdata[p] : g_prio[p-1].w_sel;
      end
    end

    assign w_we_word          = g_prio[NumWritePorts-1].w_any;
    assign w_wdata_word       = g_prio[NumWritePorts-1].w_sel;
    assign w_conflict_word[w] = g_prio[NumWritePorts-1].w_dup;
    assign w_lock_hit         = lock_i & (w_lock_addr == ADDR_WIDTH'(w));

    // Word storage, updated with the winning write port's data.
    always_ff @(posedge clk_int or negedge rst_ni) begin
      if (!rst_ni) begin
        r_q <= '0;
      end else if (w_we_word) begin
        r_q <= w_wdata_word;
      end
    end

    // Busy bit: a new producer (lock) supersedes the one retiring this cycle.
    always_ff @(posedge clk_int or negedge rst_ni) begin
      if (!rst_ni) begin
        r_busy <= 1'b0;
      end else if (w_lock_hit) begin
        r_busy <= 1'b1;
      end else if (w_we_word) begin
        r_busy <= 1'b0;
      end
    end

    assign w_busy_view[w] = r_busy;

    if (WriteThrough) begin : g_fwd
      assign w_rd_view[w] = w_we_word ? w_wdata_word : r_q;
    end else begin : g_no_fwd
      assign w_rd_view[w] = r_q;
    end
  end

  if (DummyInstructions) begin : g_dummy
    logic                 w_x0_we;
    logic [DataWidth-1:0] r0_shadow;

    // Only port 0 may write the shadow x0, and only for dummy instructions.
    assign w_x0_we = w_we[0] & (w_waddr[0] == '0) & dummy_instr_id_i;

    // Shadow x0 storage for dummy-instruction results.
    always_ff @(posedge clk_int or negedge rst_ni) begin
      if (!rst_ni) begin
        r0_shadow <= '0;
      end else if (w_x0_we) begin
        r0_shadow <= w_wdata[0];
      end
    end

    if (WriteThrough) begin : g_fwd
      assign w_rd_view[0] = !dummy_instr_id_i ? '0 :
                            (w_x0_we ? w_wdata[0] : r0_shadow);
    end else begin : g_no_fwd
      assign w_rd_view[0] = dummy_instr_id_i ? r0_shadow : '0;
    end
  end else begin : g_no_dummy
    assign w_rd_view[0] = '0;
  end

  for (genvar r = 0; r < NumReadPorts; r++) begin : g_rport
    logic [ADDR_WIDTH-1:0] w_raddr;

    assign w_raddr                           = raddr_i[5*r +: ADDR_WIDTH];
    assign rdata_o[DataWidth*r +: DataWidth] = w_rd_view[w_raddr];
    assign busy_o[r]                         = w_busy_view[w_raddr];
  end

  // One-cycle collision pulse for the edge at which two ports hit one word.
  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_conflict <= 1'b0;
    end else begin
      r_wr_conflict <= |w_conflict_word;
    end
  end

  assign wr_conflict_o = r_wr_conflict;

endmodule
`default_nettype wire

// File: tb/tb_ibex_register_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_ibex_register_file_mp
// Description : Directed self-checking bench. Three instances share stimulus:
//               write-through (default), no write-through, and RV32E with
//               dummy-instruction shadow x0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ibex_register_file_mp;

  logic        clk_int = 1'b0;
  logic        rst_ni;
  logic        dummy;
  logic [9:0]  raddr;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [1:0]  we;
  logic        lock;
  logic [4:0]  lock_addr;

  logic [63:0] rd_wt, rd_nwt, rd_e;
  logic [1:0]  busy_wt, busy_nwt, busy_e;
  logic        cf_wt, cf_nwt, cf_e;

  int total  = 0;
  int passed = 0;

  always #5 clk_int = ~clk_int;

  ibex_register_file_mp #(
    .RV32E(1'b0), .DataWidth(32), .NumReadPorts(2), .NumWritePorts(2),
    .WriteThrough(1'b1), .DummyInstructions(1'b0)
  ) dut_wt (
    .clk_int(clk_int), .rst_ni(rst_ni), .dummy_instr_id_i(dummy),
    .raddr_i(raddr), .rdata_o(rd_wt), .busy_o(busy_wt),
    .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
    .lock_i(lock), .lock_addr_i(lock_addr), .wr_conflict_o(cf_wt)
  );

  ibex_register_file_mp #(
    .RV32E(1'b0), .DataWidth(32), .NumReadPorts(2), .NumWritePorts(2),
    .WriteThrough(1'b0), .DummyInstructions(1'b0)
  ) dut_nwt (
    .clk_int(clk_int), .rst_ni(rst_ni), .dummy_instr_id_i(dummy),
    .raddr_i(raddr), .rdata_o(rd_nwt), .busy_o(busy_nwt),
    .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
    .lock_i(lock), .lock_addr_i(lock_addr), .wr_conflict_o(cf_nwt)
  );

  ibex_register_file_mp #(
    .RV32E(1'b1), .DataWidth(32), .NumReadPorts(2), .NumWritePorts(2),
    .WriteThrough(1'b1), .DummyInstructions(1'b1)
  ) dut_e (
    .clk_int(clk_int), .rst_ni(rst_ni), .dummy_instr_id_i(dummy),
    .raddr_i(raddr), .rdata_o(rd_e), .busy_o(busy_e),
    .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
    .lock_i(lock), .lock_addr_i(lock_addr), .wr_conflict_o(cf_e)
  );

  task automatic tick();
    @(posedge clk_int);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; dummy = 1'b0; raddr = '0; waddr = '0; wdata = '0;
    we = '0; lock = 1'b0; lock_addr = '0;
    #3;
    total++;
    if (rd_wt !== 64'h0 || cf_wt !== 1'b0) $display("FAIL in_reset rdata=%h conflict=%b expected 0/0", rd_wt, cf_wt);
    else passed++;
    tick();
    rst_ni = 1'b1;
    for (int a = 0; a < 32; a++) begin
      raddr = {5'(31 - a), 5'(a)};
      #1;
      total++;
      if (rd_wt !== 64'h0 || busy_wt !== 2'b00)
        $display("FAIL reset_read addr=%0d rdata=%h busy=%b expected 0/00", a, rd_wt, busy_wt);
      else passed++;
    end
    total++;
    if (cf_wt !== 1'b0) $display("FAIL reset_conflict got=%b expected 0", cf_wt);
    else passed++;
  endtask

  task automatic test_write_read();
    tick();
    raddr = {5'd0, 5'd5}; waddr = {5'd0, 5'd5}; wdata = {32'h0, 32'hDEADBEEF}; we = 2'b01;
    #2;
    total++;
    if (rd_wt[31:0] !== 32'hDEADBEEF) $display("FAIL wt_same_cycle got=%h expected deadbeef", rd_wt[31:0]);
    else passed++;
    total++;
    if (rd_nwt[31:0] !== 32'h0) $display("FAIL nwt_same_cycle got=%h expected 0", rd_nwt[31:0]);
    else passed++;
    tick();
    we = 2'b00; raddr = {5'd5, 5'd0};
    #2;
    total++;
    if (rd_wt[63:32] !== 32'hDEADBEEF || rd_nwt[63:32] !== 32'hDEADBEEF)
      $display("FAIL next_cycle_read wt=%h nwt=%h expected deadbeef", rd_wt[63:32], rd_nwt[63:32]);
    else passed++;
  endtask

  task automatic test_collision();
    tick();
    waddr = {5'd7, 5'd7}; wdata = {32'h22, 32'h11}; we = 2'b11; raddr = {5'd7, 5'd7};
    #2;
    total++;
    if (rd_wt[31:0] !== 32'h22) $display("FAIL collision_fwd got=%h expected 22", rd_wt[31:0]);
    else passed++;
    total++;
    if (cf_wt !== 1'b0) $display("FAIL conflict_early got=%b expected 0", cf_wt);
    else passed++;
    tick();
    we = 2'b00;
    #2;
    total++;
    if (rd_nwt[31:0] !== 32'h22) $display("FAIL collision_winner got=%h expected 22", rd_nwt[31:0]);
    else passed++;
    total++;
    if (cf_wt !== 1'b1 || cf_nwt !== 1'b1) $display("FAIL conflict_pulse wt=%b nwt=%b expected 1", cf_wt, cf_nwt);
    else passed++;
    tick();
    #2;
    total++;
    if (cf_wt !== 1'b0) $display("FAIL conflict_one_cycle got=%b expected 0", cf_wt);
    else passed++;
    // Two ports, distinct registers: both land, no collision.
    waddr = {5'd2, 5'd1}; wdata = {32'h200, 32'h100}; we = 2'b11;
    tick();
    we = 2'b00; raddr = {5'd2, 5'd1};
    #2;
    total++;
    if (rd_nwt !== {32'h200, 32'h100}) $display("FAIL distinct_writes got=%h expected 0000020000000100", rd_nwt);
    else passed++;
    total++;
    if (cf_wt !== 1'b0) $display("FAIL distinct_no_conflict got=%b expected 0", cf_wt);
    else passed++;
    // Both ports to x0: discarded, no collision.
    waddr = {5'd0, 5'd0}; wdata = {32'h33, 32'h44}; we = 2'b11; dummy = 1'b0; raddr = {5'd0, 5'd0};
    #2;
    total++;
    if (rd_wt !== 64'h0) $display("FAIL x0_fwd got=%h expected 0", rd_wt);
    else passed++;
    tick();
    we = 2'b00;
    #2;
    total++;
    if (cf_wt !== 1'b0 || cf_e !== 1'b0 || rd_wt !== 64'h0)
      $display("FAIL x0_write conflict=%b/%b rdata=%h expected 0/0/0", cf_wt, cf_e, rd_wt);
    else passed++;
  endtask

  task automatic test_scoreboard();
    lock = 1'b1; lock_addr = 5'd9; raddr = {5'd9, 5'd9};
    #1;
    total++;
    if (busy_wt !== 2'b00) $display("FAIL busy_before_lock got=%b expected 00", busy_wt);
    else passed++;
    tick();
    lock = 1'b0;
    #2;
    total++;
    if (busy_wt !== 2'b11) $display("FAIL busy_after_lock got=%b expected 11", busy_wt);
    else passed++;
    waddr = {5'd0, 5'd9}; wdata = {32'h0, 32'h99}; we = 2'b01;
    #2;
    total++;
    if (busy_wt !== 2'b11) $display("FAIL busy_not_forwarded got=%b expected 11", busy_wt);
    else passed++;
    tick();
    we = 2'b00;
    #2;
    total++;
    if (busy_wt !== 2'b00) $display("FAIL busy_cleared got=%b expected 00", busy_wt);
    else passed++;
    lock = 1'b1; lock_addr = 5'd9; we = 2'b01;
    tick();
    lock = 1'b0; we = 2'b00;
    #2;
    total++;
    if (busy_wt !== 2'b11) $display("FAIL lock_beats_write got=%b expected 11", busy_wt);
    else passed++;
    lock = 1'b1; lock_addr = 5'd0; raddr = {5'd0, 5'd0};
    tick();
    lock = 1'b0;
    #2;
    total++;
    if (busy_wt !== 2'b00) $display("FAIL lock_x0 got=%b expected 00", busy_wt);
    else passed++;
  endtask

  task automatic test_dummy();
    dummy = 1'b1; waddr = {5'd0, 5'd0}; wdata = {32'h0, 32'hA5A5}; we = 2'b01; raddr = {5'd0, 5'd0};
    #2;
    total++;
    if (rd_e[31:0] !== 32'hA5A5 || rd_wt[31:0] !== 32'h0)
      $display("FAIL dummy_fwd shadow=%h plain=%h expected a5a5/0", rd_e[31:0], rd_wt[31:0]);
    else passed++;
    tick();
    we = 2'b00;
    #2;
    total++;
    if (rd_e[31:0] !== 32'hA5A5) $display("FAIL dummy_read got=%h expected a5a5", rd_e[31:0]);
    else passed++;
    dummy = 1'b0;
    #1;
    total++;
    if (rd_e[31:0] !== 32'h0) $display("FAIL dummy_off_read got=%h expected 0", rd_e[31:0]);
    else passed++;
    dummy = 1'b1; wdata = {32'hFFFF, 32'h0}; we = 2'b10;
    tick();
    we = 2'b00;
    #2;
    total++;
    if (rd_e[31:0] !== 32'hA5A5) $display("FAIL dummy_port1_discard got=%h expected a5a5", rd_e[31:0]);
    else passed++;
    dummy = 1'b0;
  endtask

  task automatic test_rv32e();
    waddr = {5'd0, 5'b10011}; wdata = {32'h0, 32'h3333}; we = 2'b01;
    tick();
    we = 2'b00; raddr = {5'b10011, 5'd3};
    #2;
    total++;
    if (rd_e !== {32'h3333, 32'h3333}) $display("FAIL rv32e_alias got=%h expected 0000333300003333", rd_e);
    else passed++;
    total++;
    if (rd_wt !== {32'h3333, 32'h0}) $display("FAIL rv32i_no_alias got=%h expected 0000333300000000", rd_wt);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [9:0] pairs [4];
    waddr = {5'd10, 5'd10}; wdata = {32'hBBBB, 32'hAAAA}; we = 2'b11; lock = 1'b1; lock_addr = 5'd4;
    tick();
    waddr = {5'd0, 5'd11}; wdata = {32'h0, 32'hCCCC}; we = 2'b01; lock_addr = 5'd12; raddr = {5'd4, 5'd10};
    #1;
    total++;
    if (cf_wt !== 1'b1 || rd_nwt[31:0] !== 32'hBBBB || busy_nwt !== 2'b10)
      $display("FAIL pre_reset conflict=%b rdata=%h busy=%b expected 1/bbbb/10", cf_wt, rd_nwt[31:0], busy_nwt);
    else passed++;
    rst_ni = 1'b0;
    #1;
    total++;
    if (cf_wt !== 1'b0 || rd_wt !== 64'h0 || busy_wt !== 2'b00)
      $display("FAIL async_reset conflict=%b rdata=%h busy=%b expected 0/0/00", cf_wt, rd_wt, busy_wt);
    else passed++;
    tick();
    tick();
    rst_ni = 1'b1; we = 2'b00; lock = 1'b0;
    pairs[0] = {5'd4, 5'd10};
    pairs[1] = {5'd12, 5'd11};
    pairs[2] = {5'd9, 5'd5};
    pairs[3] = {5'd7, 5'd2};
    for (int i = 0; i < 4; i++) begin
      raddr = pairs[i];
      #1;
      total++;
      if (rd_wt !== 64'h0 || rd_nwt !== 64'h0 || busy_wt !== 2'b00)
        $display("FAIL post_reset idx=%0d rdata=%h/%h busy=%b expected 0/0/00", i, rd_wt, rd_nwt, busy_wt);
      else passed++;
    end
    dummy = 1'b1; raddr = {5'd3, 5'd0};
    #1;
    total++;
    if (rd_e !== 64'h0) $display("FAIL post_reset_shadow got=%h expected 0", rd_e);
    else passed++;
    dummy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_collision();
    test_scoreboard();
    test_dummy();
    test_rv32e();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
